// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Prefetch FIFO entry: instruction word plus the word address it came from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO: synchronous push/pop, flush wins over both, occupancy out.
// The head entry is read combinationally; storage resets to zero so the
// head reads as all-zero out of reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     wdata,
  output entry_t                     rdata,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t         mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdata = mem[rd_ptr];

  // Pointer, count and storage update; flush drops any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the pc, issues credit-limited reads to a
// one-cycle-latency instruction memory, buffers responses in a prefetch FIFO
// and hands them to decode over valid/ready. Handles redirect and halt.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_idle
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tag;       // pc of the read whose data lands this cycle
  logic              inflight;  // a read was issued last cycle
  logic              run;       // low for the first cycle out of reset
  logic              squash;
  logic              push, pop;
  logic [CW-1:0]     occ;
  logic [CW:0]       used;
  fetch_entry_t      head, wentry;

  // With one-cycle memory latency the in-flight read lands in the same cycle
  // a redirect is seen, so squashing it simply suppresses its push.
  assign squash = redirect_valid && inflight;
  assign push   = inflight && !squash;
  assign pop    = (occ != '0) && inst_ready;

  // Credit: entries held plus the landing read, net of this cycle's pop.
  assign used    = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_en = run && (state == FETCH) && !halt && !redirect_valid &&
                   (used < (CW+1)'(DEPTH));

  assign imem_addr   = pc;
  assign wentry.pc   = tag;
  assign wentry.data = imem_rdata;
  assign inst_valid  = (occ != '0);
  assign inst_data   = head.data;
  assign inst_pc     = head.pc;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .occ   (occ)
  );

  // pc advance / redirect load, in-flight tag tracking and start-up gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= imem_en;
      if (imem_en) tag <= pc;
      if (redirect_valid) pc <= redirect_pc;
      else if (imem_en)   pc <= pc + 1'b1;
    end
  end

  // Halt sequencing FSM; fetch_idle lags entry into HALTED by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      fetch_idle <= 1'b1;
    end else begin
      fetch_idle <= (state == HALTED);
      case (state)
        FETCH:   if (halt) state <= push ? DRAIN : HALTED;
        DRAIN:   state <= halt ? HALTED : FETCH;
        HALTED:  if (!halt) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
